// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, converter state encoding and the
// digit-count helper used to size BCD result buses.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of decimal digits needed to print 2^width-1.
    function automatic int digits(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit add-3 correction applied before each shift of the
// double-dabble converter.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    // Digits of 5 or more would exceed 9 after doubling, so pre-add 3.
    always_comb begin
        q = (d >= BCD_DIGIT_W'(5)) ? d + BCD_DIGIT_W'(3) : d;
    end

endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, with a
// start/ready/valid handshake.
// Optional feature macro: BCD_SIGNED_EN (two's complement input, sign on neg).
//
// state | meaning
// IDLE  | ready high, waiting for start
// CONV  | WIDTH shift-add-3 iterations, MSB of operand first
// DONE  | publish scratch to bcd; valid pulses on the following cycle
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = digits(WIDTH)
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              x,
    output logic                          ready,
    output logic                          valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          neg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   operand;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic               load;
    logic               shift;
    logic               finish;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (scratch_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD_SIGNED_EN
    logic neg_pend;

    // Convert the magnitude; the wrap of the most negative value to
    // 2^(WIDTH-1) is correct when read as unsigned.
    assign operand = x[WIDTH-1] ? (~x) + WIDTH'(1) : x;

    // Capture the sign on accept, publish it together with the digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_pend <= 1'b0;
            neg      <= 1'b0;
        end else begin
            if (load)
                neg_pend <= x[WIDTH-1];
            if (finish)
                neg <= neg_pend;
        end
    end
`else
    assign operand = x;
    assign neg     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                shift = 1'b1;
                if (count == CNT_W'(WIDTH - 1))
                    state_next = DONE;
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand load, shift-add-3 iterations, result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            shreg   <= '0;
            scratch <= '0;
            bcd     <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= finish;
            if (load) begin
                count   <= '0;
                shreg   <= operand;
                scratch <= '0;
            end else if (shift) begin
                count            <= count + CNT_W'(1);
                {scratch, shreg} <= {scratch_adj, shreg} << 1;
            end
            if (finish)
                bcd <= scratch;
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
module tb_bcd_convert_seq;

    logic        clk;
    logic        rst_n;

    logic        start8,  start16, start32;
    logic [7:0]  x8;
    logic [15:0] x16;
    logic [31:0] x32;
    logic        ready8,  ready16, ready32;
    logic        valid8,  valid16, valid32;
    logic [11:0] bcd8;
    logic [19:0] bcd16;
    logic [39:0] bcd32;
    logic        neg8,    neg16,   neg32;

    int checks = 0;
    int errors = 0;

    bcd_convert_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8),
        .ready(ready8), .valid(valid8), .bcd(bcd8), .neg(neg8)
    );

    bcd_convert_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .x(x16),
        .ready(ready16), .valid(valid16), .bcd(bcd16), .neg(neg16)
    );

    bcd_convert_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .x(x32),
        .ready(ready32), .valid(valid32), .bcd(bcd32), .neg(neg32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits of the value read as WIDTH-bit (signed when the macro is on).
    function automatic logic [39:0] model_bcd(input int w, input logic [31:0] xv, output logic n);
        longint unsigned mask;
        longint unsigned v;
        logic [39:0]     r;
        mask = (64'd1 << w) - 64'd1;
        v    = {32'd0, xv} & mask;
        n    = 1'b0;
`ifdef BCD_SIGNED_EN
        if (((v >> (w - 1)) & 64'd1) != 0) begin
            n = 1'b1;
            v = ((64'd1 << w) - v) & mask;
        end
`endif
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(v % 64'd10);
            v = v / 64'd10;
        end
        return r;
    endfunction

    function automatic logic get_ready(input int w);
        case (w)
            8:       return ready8;
            16:      return ready16;
            default: return ready32;
        endcase
    endfunction

    function automatic logic get_valid(input int w);
        case (w)
            8:       return valid8;
            16:      return valid16;
            default: return valid32;
        endcase
    endfunction

    function automatic logic get_neg(input int w);
        case (w)
            8:       return neg8;
            16:      return neg16;
            default: return neg32;
        endcase
    endfunction

    function automatic logic [39:0] get_bcd(input int w);
        case (w)
            8:       return {28'd0, bcd8};
            16:      return {20'd0, bcd16};
            default: return bcd32;
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [31:0] xv);
        case (w)
            8:       begin start8  = s; x8  = xv[7:0];  end
            16:      begin start16 = s; x16 = xv[15:0]; end
            default: begin start32 = s; x32 = xv;       end
        endcase
    endtask

    // One full handshake: pulse start, wait for valid with a bound, check result.
    task automatic convert(input int w, input logic [31:0] xv);
        logic [39:0] eb;
        logic        en;
        int          cyc;
        bit          seen;
        bit          rdy_ok;
        eb = model_bcd(w, xv, en);
        @(negedge clk);
        check("ready_idle", 64'(get_ready(w)), 64'd1);
        drive(w, 1'b1, xv);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, $urandom);
        cyc    = 0;
        seen   = 0;
        rdy_ok = 1;
        while (!seen && cyc < 200) begin
            if (get_valid(w)) begin
                seen = 1;
            end else begin
                if (get_ready(w)) rdy_ok = 0;
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
        end
        check("valid_seen", 64'(seen), 64'd1);
        check("latency", 64'(cyc), 64'(w + 1));
        check("ready_low", 64'(rdy_ok), 64'd1);
        check("bcd", 64'(get_bcd(w)), 64'(eb));
        check("neg", 64'(get_neg(w)), 64'(en));
        @(posedge clk);
        @(negedge clk);
        check("valid_pulse", 64'(get_valid(w)), 64'd0);
        check("bcd_hold", 64'(get_bcd(w)), 64'(eb));
    endtask

    logic [7:0] vals2 [3];
    int         idx;
    int         last;
    int         cyc;
    int         nv;

    initial begin
        rst_n = 1'b0;
        drive(8, 1'b0, 0);
        drive(16, 1'b0, 0);
        drive(32, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready8), 64'd1);
        check("rst_valid", 64'(valid8), 64'd0);
        check("rst_bcd", 64'(bcd8), 64'd0);
        check("rst_neg", 64'(neg8), 64'd0);
        rst_n = 1'b1;

        // Full-scale 8-bit value.
        convert(8, 32'd255);
        check("t1_bcd", 64'(bcd8), 64'h255);

        // Back-to-back with start held; x scrambled while converting.
        vals2[0] = 8'd0;
        vals2[1] = 8'd99;
        vals2[2] = 8'd100;
        @(negedge clk);
        drive(8, 1'b1, 32'(vals2[0]));
        @(posedge clk);
        idx  = 0;
        last = 0;
        cyc  = 0;
        while (idx < 3 && cyc < 60) begin
            @(negedge clk);
            if (valid8) begin
                check("t2_bcd", 64'(bcd8), (idx == 0) ? 64'h000 : (idx == 1) ? 64'h099 : 64'h100);
                if (idx > 0) check("t2_spacing", 64'(cyc - last), 64'd10);
                last = cyc;
                idx++;
                if (idx < 3) x8 = vals2[idx];
                else         start8 = 1'b0;
            end else begin
                x8 = 8'($urandom);
            end
            @(posedge clk);
            cyc++;
        end
        check("t2_count", 64'(idx), 64'd3);
        start8 = 1'b0;
        repeat (2) @(negedge clk);

        // Start re-pulsed mid-conversion is ignored.
        @(negedge clk);
        drive(8, 1'b1, 32'd37);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, $urandom);
        repeat (2) @(negedge clk);
        drive(8, 1'b1, 32'd200);
        @(negedge clk);
        drive(8, 1'b0, 32'd0);
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid8) begin
                nv++;
                check("t3_bcd", 64'(bcd8), 64'h037);
            end
        end
        check("t3_valids", 64'(nv), 64'd1);

        // Reset during the 4th conversion cycle.
        @(negedge clk);
        drive(8, 1'b1, 32'd99);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_ready", 64'(ready8), 64'd1);
        check("t4_valid", 64'(valid8), 64'd0);
        check("t4_bcd", 64'(bcd8), 64'd0);
        check("t4_neg", 64'(neg8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (valid8) nv++;
        end
        check("t4_no_valid", 64'(nv), 64'd0);
        convert(8, 32'd128);
        check("t4_bcd_after", 64'(bcd8), 64'h128);

        // Wide widths at full scale.
        convert(16, 32'd65535);
        convert(32, 32'hFFFF_FFFF);
`ifndef BCD_SIGNED_EN
        check("t5_bcd16", 64'(bcd16), 64'h65535);
        check("t5_bcd32", 64'(bcd32), 64'h42_9496_7295);
`endif

        // Sign boundaries (unsigned readings when the macro is off).
        convert(8, 32'h80);
`ifdef BCD_SIGNED_EN
        check("t6_80_neg", 64'(neg8), 64'd1);
`else
        check("t6_80_neg", 64'(neg8), 64'd0);
`endif
        check("t6_80_bcd", 64'(bcd8), 64'h128);
        convert(8, 32'hFF);
        convert(8, 32'h7F);
        check("t6_7f_bcd", 64'(bcd8), 64'h127);

        // Random sweep across all widths.
        for (int i = 0; i < 300; i++) convert(8, $urandom);
        for (int i = 0; i < 300; i++) convert(16, $urandom);
        for (int i = 0; i < 400; i++) convert(32, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
